// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite motion table: keycodes,
// host write field codes, sweep FSM states and the empty-slot ID.
package sprite_pkg;

    // ID value that marks a slot as unused (default 4-bit ID width)
    localparam logic [3:0] EMPTY_ID = 4'hF;

    // USB HID keycodes that steer the player sprite
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    // Host write field selector
    typedef enum logic [1:0] {
        FIELD_POS  = 2'd0,
        FIELD_VEL  = 2'd1,
        FIELD_ID   = 2'd2,
        FIELD_RSVD = 2'd3
    } wr_field_e;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    // True when the keycode is one of the four movement keys
    function automatic logic is_move_key(input logic [7:0] code);
        case (code)
            KEY_W, KEY_S, KEY_A, KEY_D: is_move_key = 1'b1;
            default:                    is_move_key = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position step: adds a signed velocity to an unsigned position,
// clamps the result into [0, MAX] and optionally reflects the velocity
// when a clamp happened. Purely combinational.
module sprite_axis_step #(
    parameter int W   = 10,
    parameter int VW  = 4,
    parameter int MAX = 624
) (
    input  logic [W-1:0]         pos,
    input  logic signed [VW-1:0] vel,
    input  logic                 bounce_en,
    output logic [W-1:0]         new_pos,
    output logic signed [VW-1:0] new_vel
);

    localparam logic signed [W+1:0]  MAX_S = (W+2)'(MAX);
    localparam logic [W-1:0]         MAX_P = W'(MAX);
    localparam logic signed [VW-1:0] V_MIN = {1'b1, {(VW-1){1'b0}}};
    localparam logic signed [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};

    // Negation that maps the most negative value to the most positive one
    function automatic logic signed [VW-1:0] neg_sat(input logic signed [VW-1:0] v);
        if (v == V_MIN) begin
            neg_sat = V_MAX;
        end else begin
            neg_sat = -v;
        end
    endfunction

    logic signed [W+1:0] w_pos_ext;
    logic signed [W+1:0] w_vel_ext;
    logic signed [W+1:0] w_sum;
    logic                w_clamped;

    // Two guard bits keep the sum free of overflow for any pos/vel pair
    assign w_pos_ext = $signed({2'b00, pos});
    assign w_vel_ext = $signed({{(W+2-VW){vel[VW-1]}}, vel});
    assign w_sum     = w_pos_ext + w_vel_ext;

    // Clamp the stepped coordinate into the legal window
    always_comb begin
        if (w_sum[W+1]) begin
            new_pos   = '0;
            w_clamped = 1'b1;
        end else if (w_sum > MAX_S) begin
            new_pos   = MAX_P;
            w_clamped = 1'b1;
        end else begin
            new_pos   = w_sum[W-1:0];
            w_clamped = 1'b0;
        end
    end

    // Reflect the velocity on a clamp when bouncing is enabled
    always_comb begin
        if (bounce_en && w_clamped) begin
            new_vel = neg_sat(vel);
        end else begin
            new_vel = vel;
        end
    end

endmodule

// File: rtl/sprite_motion_table.sv
// Per-frame sprite state engine. Holds position, velocity and ID for
// N_SPR slots, written by the host while idle. Each falling edge of vs
// sweeps the slots one per cycle, stepping live sprites with edge
// clamp/bounce; the PLAYER slot is steered by the USB keycode instead.
module sprite_motion_table
    import sprite_pkg::*;
#(
    parameter int N_SPR  = 16,
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int VW     = 4,
    parameter int ID_W   = 4,
    parameter int X_MAX  = 624,
    parameter int Y_MAX  = 464,
    parameter int STEP   = 2,
    parameter int PLAYER = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      vs,
    input  logic [7:0]                keycode,
    input  logic                      wr_en,
    output logic                      wr_ready,
    input  logic [$clog2(N_SPR)-1:0]  wr_idx,
    input  logic [1:0]                wr_field,
    input  logic [XW+YW-1:0]          wr_data,
    output logic [N_SPR*XW-1:0]       pos_x,
    output logic [N_SPR*YW-1:0]       pos_y,
    output logic [N_SPR*ID_W-1:0]     sprite_id,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic [15:0]               frame_cnt
);

    localparam int                   IW         = $clog2(N_SPR);
    localparam logic [IW-1:0]        LAST_IDX   = IW'(N_SPR - 1);
    localparam logic [IW-1:0]        PLAYER_IDX = IW'(PLAYER);
    localparam logic [ID_W-1:0]      EMPTY      = {ID_W{1'b1}};
    localparam logic signed [VW-1:0] STEP_P     = VW'(STEP);
    localparam logic signed [VW-1:0] STEP_N     = VW'(-STEP);

    // Slot storage
    logic [XW-1:0]          r_pos_x [N_SPR];
    logic [YW-1:0]          r_pos_y [N_SPR];
    logic signed [VW-1:0]   r_vel_x [N_SPR];
    logic signed [VW-1:0]   r_vel_y [N_SPR];
    logic [ID_W-1:0]        r_id    [N_SPR];

    // Control
    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [IW-1:0]          r_idx;
    logic                   r_vs_d;
    logic                   w_start;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ready;
    logic                   r_overrun;
    logic [15:0]            r_frame_cnt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_ready_nxt;
    logic                   w_wr_accept;

    // Datapath for the slot under update
    logic                   w_is_player;
    logic                   w_slot_live;
    logic                   w_bounce_en;
    logic signed [VW-1:0]   w_key_vx;
    logic signed [VW-1:0]   w_key_vy;
    logic signed [VW-1:0]   w_cur_vx;
    logic signed [VW-1:0]   w_cur_vy;
    logic [XW-1:0]          w_new_x;
    logic [YW-1:0]          w_new_y;
    logic signed [VW-1:0]   w_new_vx;
    logic signed [VW-1:0]   w_new_vy;

    // Frame start is the falling edge of vs against its one-cycle delay
    assign w_start     = r_vs_d & ~vs;
    assign w_wr_accept = wr_en & r_ready;

    // Capture vs for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_vs_d <= 1'b0;
        end else begin
            r_vs_d <= vs;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = SWEEP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SWEEP: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SWEEP;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they register in step with it
    always_comb begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            IDLE:    w_ready_nxt = 1'b1;
            SWEEP:   w_busy_nxt  = 1'b1;
            DONE: begin
                w_done_nxt  = 1'b1;
                w_ready_nxt = 1'b1;
            end
            default: w_ready_nxt = 1'b1;
        endcase
    end

    // Registered status outputs, sweep index, frame counter and overrun flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
            r_idx       <= '0;
            r_frame_cnt <= 16'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
            if (r_state == SWEEP) begin
                r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
            end else begin
                r_idx <= '0;
            end
            if (w_done_nxt) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            // A frame edge is lost whenever the controller is not idle
            if (w_start && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Player velocity decoded from the held key
    always_comb begin
        w_key_vx = '0;
        w_key_vy = '0;
        if (is_move_key(keycode)) begin
            case (keycode)
                KEY_A:   w_key_vx = STEP_N;
                KEY_D:   w_key_vx = STEP_P;
                KEY_W:   w_key_vy = STEP_N;
                KEY_S:   w_key_vy = STEP_P;
                default: begin
                    w_key_vx = '0;
                    w_key_vy = '0;
                end
            endcase
        end else begin
            w_key_vx = '0;
            w_key_vy = '0;
        end
    end

    // Select the velocity fed to the steppers for the current slot
    always_comb begin
        w_is_player = (r_idx == PLAYER_IDX);
        w_slot_live = (r_id[r_idx] != EMPTY);
        w_bounce_en = ~w_is_player;
        if (w_is_player) begin
            w_cur_vx = w_key_vx;
            w_cur_vy = w_key_vy;
        end else begin
            w_cur_vx = r_vel_x[r_idx];
            w_cur_vy = r_vel_y[r_idx];
        end
    end

    sprite_axis_step #(
        .W   (XW),
        .VW  (VW),
        .MAX (X_MAX)
    ) u_step_x (
        .pos       (r_pos_x[r_idx]),
        .vel       (w_cur_vx),
        .bounce_en (w_bounce_en),
        .new_pos   (w_new_x),
        .new_vel   (w_new_vx)
    );

    sprite_axis_step #(
        .W   (YW),
        .VW  (VW),
        .MAX (Y_MAX)
    ) u_step_y (
        .pos       (r_pos_y[r_idx]),
        .vel       (w_cur_vy),
        .bounce_en (w_bounce_en),
        .new_pos   (w_new_y),
        .new_vel   (w_new_vy)
    );

    // Slot storage: host writes while idle, one slot updated per sweep cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_pos_x[i] <= '0;
                r_pos_y[i] <= '0;
                r_vel_x[i] <= '0;
                r_vel_y[i] <= '0;
                r_id[i]    <= EMPTY;
            end
        end else if (w_wr_accept) begin
            case (wr_field_e'(wr_field))
                FIELD_POS: begin
                    r_pos_x[wr_idx] <= wr_data[XW-1:0];
                    r_pos_y[wr_idx] <= wr_data[XW+YW-1:XW];
                end
                FIELD_VEL: begin
                    r_vel_x[wr_idx] <= wr_data[VW-1:0];
                    r_vel_y[wr_idx] <= wr_data[2*VW-1:VW];
                end
                FIELD_ID:  r_id[wr_idx] <= wr_data[ID_W-1:0];
                default:   ;
            endcase
        end else if ((r_state == SWEEP) && w_slot_live) begin
            r_pos_x[r_idx] <= w_new_x;
            r_pos_y[r_idx] <= w_new_y;
            // The player's stored velocity is kept for when it stops being steered
            if (!w_is_player) begin
                r_vel_x[r_idx] <= w_new_vx;
                r_vel_y[r_idx] <= w_new_vy;
            end
        end
    end

    // Flatten slot storage onto the packed output buses
    for (genvar gi = 0; gi < N_SPR; gi++) begin : g_pack
        assign pos_x[gi*XW +: XW]         = r_pos_x[gi];
        assign pos_y[gi*YW +: YW]         = r_pos_y[gi];
        assign sprite_id[gi*ID_W +: ID_W] = r_id[gi];
    end

    assign wr_ready  = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sprite_motion_table.sv
// Self-checking bench for sprite_motion_table: directed scenarios followed
// by randomized host writes and keycodes, checked against an integer model.
module tb_sprite_motion_table;

    localparam int N_SPR  = 16;
    localparam int XW     = 10;
    localparam int YW     = 10;
    localparam int ID_W   = 4;
    localparam int X_MAX  = 624;
    localparam int Y_MAX  = 464;
    localparam int PLAYER = 0;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  vs;
    logic [7:0]            keycode;
    logic                  wr_en;
    logic                  wr_ready;
    logic [3:0]            wr_idx;
    logic [1:0]            wr_field;
    logic [XW+YW-1:0]      wr_data;
    logic [N_SPR*XW-1:0]   pos_x;
    logic [N_SPR*YW-1:0]   pos_y;
    logic [N_SPR*ID_W-1:0] sprite_id;
    logic                  busy;
    logic                  done;
    logic                  overrun;
    logic [15:0]           frame_cnt;

    sprite_motion_table dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .vs        (vs),
        .keycode   (keycode),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .sprite_id (sprite_id),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int m_x  [N_SPR];
    int m_y  [N_SPR];
    int m_vx [N_SPR];
    int m_vy [N_SPR];
    int m_id [N_SPR];
    int m_frames;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sext4(input int v);
        int t;
        t = v & 15;
        return (t >= 8) ? t - 16 : t;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N_SPR; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_id[i] = 15;
        end
        m_frames = 0;
    endtask

    task automatic m_write(input int idx, input int field, input int data);
        case (field)
            0: begin m_x[idx] = data & 1023; m_y[idx] = (data >> 10) & 1023; end
            1: begin m_vx[idx] = sext4(data); m_vy[idx] = sext4(data >> 4); end
            2: m_id[idx] = data & 15;
            default: ;
        endcase
    endtask

    // One axis: move, clamp into [0,mx], reflect velocity if allowed
    task automatic m_axis(input int p, input int v, input int vin, input int mx, input bit bnc,
                          output int p_o, output int v_o);
        int n;
        bit cl;
        n  = p + vin;
        cl = 1'b0;
        if (n < 0) begin p_o = 0; cl = 1'b1; end
        else if (n > mx) begin p_o = mx; cl = 1'b1; end
        else p_o = n;
        v_o = v;
        if (bnc && cl) v_o = (v == -8) ? 7 : -v;
    endtask

    task automatic m_frame();
        int kvx, kvy, np, nv;
        kvx = (keycode == 8'h04) ? -2 : (keycode == 8'h07) ? 2 : 0;
        kvy = (keycode == 8'h1A) ? -2 : (keycode == 8'h16) ? 2 : 0;
        for (int i = 0; i < N_SPR; i++) begin
            if (m_id[i] != 15) begin
                if (i == PLAYER) begin
                    m_axis(m_x[i], m_vx[i], kvx, X_MAX, 1'b0, np, nv); m_x[i] = np;
                    m_axis(m_y[i], m_vy[i], kvy, Y_MAX, 1'b0, np, nv); m_y[i] = np;
                end else begin
                    m_axis(m_x[i], m_vx[i], m_vx[i], X_MAX, 1'b1, np, nv); m_x[i] = np; m_vx[i] = nv;
                    m_axis(m_y[i], m_vy[i], m_vy[i], Y_MAX, 1'b1, np, nv); m_y[i] = np; m_vy[i] = nv;
                end
            end
        end
        m_frames = (m_frames + 1) % 65536;
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < N_SPR; i++) begin
            check($sformatf("%s_x%0d", tag, i),  32'(pos_x[i*XW +: XW]),       m_x[i]);
            check($sformatf("%s_y%0d", tag, i),  32'(pos_y[i*YW +: YW]),       m_y[i]);
            check($sformatf("%s_id%0d", tag, i), 32'(sprite_id[i*ID_W +: ID_W]), m_id[i]);
        end
    endtask

    task automatic host_write(input int idx, input int field, input int data);
        @(negedge Clk);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_field = 2'(field); wr_data = 20'(data);
        @(negedge Clk);
        wr_en = 1'b0;
        m_write(idx, field, data);
    endtask

    // Drive one vs falling edge and wait for done. Options: a second vs fall
    // at busy-cycle glitch_at, a dropped write during the sweep, or a write
    // issued in the same cycle as the vs fall.
    task automatic run_frame(input int glitch_at, input bit drop_wr, input bit wr_with_vs,
                             input int wi, input int wf, input int wd);
        int lat;
        @(negedge Clk);
        vs = 1'b0;
        if (wr_with_vs) begin
            wr_en = 1'b1; wr_idx = 4'(wi); wr_field = 2'(wf); wr_data = 20'(wd);
            m_write(wi, wf, wd);
        end
        @(negedge Clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            vs = (glitch_at != 0 && k == glitch_at) ? 1'b0 : 1'b1;
            if (drop_wr && k == 5) begin
                wr_en = 1'b1; wr_idx = 4'(wi); wr_field = 2'(wf); wr_data = 20'(wd);
            end else begin
                wr_en = 1'b0;
            end
            @(negedge Clk);
        end
        wr_en = 1'b0;
        vs    = 1'b1;
        check("latency", lat, N_SPR + 1);
        check("busy_in_done", 32'(busy), 0);
        m_frame();
        check("frame_cnt", 32'(frame_cnt), m_frames);
        @(negedge Clk);
        check("done_pulse", 32'(done), 0);
        check("ready_after", 32'(wr_ready), 1);
    endtask

    initial begin
        int d, sel;
        Reset = 1'b1; vs = 1'b1; keycode = 8'h00; wr_en = 1'b0;
        wr_idx = 4'd0; wr_field = 2'd0; wr_data = '0;
        m_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Reset state
        check("rst_ready", 32'(wr_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_fcnt", 32'(frame_cnt), 0);
        check_slots("rst");

        // Slot 3 basic step
        host_write(3, 0, (50 << 10) | 100);
        host_write(3, 1, ((-2 & 15) << 4) | 3);
        host_write(3, 2, 1);
        run_frame(0, 1'b0, 1'b0, 0, 0, 0);
        check("s3_x", 32'(pos_x[3*XW +: XW]), 103);
        check("s3_y", 32'(pos_y[3*YW +: YW]), 48);
        check("s3_fcnt", 32'(frame_cnt), 1);
        check_slots("s3");

        // Slot 5 right-edge clamp and bounce
        host_write(5, 0, 622);
        host_write(5, 1, 4);
        host_write(5, 2, 2);
        run_frame(0, 1'b0, 1'b0, 0, 0, 0);
        check("s5_clamp", 32'(pos_x[5*XW +: XW]), 624);
        run_frame(0, 1'b0, 1'b0, 0, 0, 0);
        check("s5_bounce", 32'(pos_x[5*XW +: XW]), 620);
        check_slots("s5");

        // Player steering
        host_write(0, 2, 0);
        keycode = 8'h04;
        run_frame(0, 1'b0, 1'b0, 0, 0, 0);
        check("pl_left_edge", 32'(pos_x[0 +: XW]), 0);
        keycode = 8'h07;
        repeat (3) run_frame(0, 1'b0, 1'b0, 0, 0, 0);
        check("pl_right3", 32'(pos_x[0 +: XW]), 6);
        check_slots("pl");
        keycode = 8'h00;

        // Overrun: second vs fall while sweeping
        check("ovr_before", 32'(overrun), 0);
        run_frame(4, 1'b0, 1'b0, 0, 0, 0);
        check("ovr_after", 32'(overrun), 1);
        check_slots("ovr");

        // Write during sweep is dropped
        run_frame(0, 1'b1, 1'b0, 3, 0, (200 << 10) | 200);
        check_slots("drop");

        // Write in the same cycle as the vs fall is stepped
        host_write(7, 2, 5);
        host_write(7, 1, 8'h11);
        run_frame(0, 1'b0, 1'b1, 7, 0, (10 << 10) | 20);
        check("wv_x", 32'(pos_x[7*XW +: XW]), 21);
        check("wv_y", 32'(pos_y[7*YW +: YW]), 11);
        check_slots("wv");

        // Randomized writes and keycodes
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 4)) begin
                d = int'($urandom & 32'h000F_FFFF);
                host_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), d);
            end
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: keycode = 8'h00;
                1: keycode = 8'h1A;
                2: keycode = 8'h16;
                3: keycode = 8'h04;
                4: keycode = 8'h07;
                default: keycode = 8'($urandom_range(0, 255));
            endcase
            run_frame(0, 1'b0, 1'b0, 0, 0, 0);
            check_slots($sformatf("rnd%0d", f));
        end

        // Reset in the middle of a sweep
        @(negedge Clk);
        vs = 1'b0;
        @(negedge Clk);
        vs = 1'b1;
        repeat (4) @(negedge Clk);
        check("mid_busy", 32'(busy), 1);
        Reset = 1'b1;
        #1;
        m_reset();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_fcnt", 32'(frame_cnt), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        check("mid_rst_ready", 32'(wr_ready), 1);
        check_slots("mid_rst");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
